// File: rtl/fetch_align.sv
// rtl/fetch_align.sv - instruction fetch with a two-word buffer feeding the decode stage.
// Compressed (RVC) halfword alignment is enabled by defining RVC_EN.
module fetch_align #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic            redirect,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic            if_rvc,
  output logic            fetch_stall,
  output logic            misalign_fault
);

  localparam int TW = XLEN - 2;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state_q;
  logic [TW-1:0] tag_q [2];
  logic [31:0]   data_q [2];
  logic [1:0]    vld_q;
  logic          pend_q;
  logic [TW-1:0] pend_tag_q;

  logic [TW-1:0] w_tag;
  logic [TW-1:0] n_tag;
  logic [1:0]    vld_eff;
  logic          w_hit;
  logic          n_hit;
  logic [31:0]   w_data;
  logic [31:0]   n_data;
  logic          need_n;
  logic          fault;
  logic          req_raw;
  logic [TW-1:0] req_tag;
  logic          wr_sel;
  logic [31:0]   instr_c;
  logic          rvc_c;
  logic          unused_bits;

  assign w_tag = pc[XLEN-1:2];
  assign n_tag = w_tag + TW'(1);

  // A redirect makes the whole buffer stale in the same cycle it is seen.
  assign vld_eff = redirect ? 2'b00 : vld_q;

  always_comb begin
    w_hit  = 1'b0;
    n_hit  = 1'b0;
    w_data = '0;
    n_data = '0;
    for (int i = 0; i < 2; i++) begin
      if (vld_eff[i] && (tag_q[i] == w_tag)) begin
        w_hit  = 1'b1;
        w_data = data_q[i];
      end
      if (vld_eff[i] && (tag_q[i] == n_tag)) begin
        n_hit  = 1'b1;
        n_data = data_q[i];
      end
    end
  end

`ifdef RVC_EN
  assign fault  = 1'b0;
  assign need_n = pc[1] && (w_data[17:16] == 2'b11);

  always_comb begin
    rvc_c   = 1'b0;
    instr_c = w_data;
    if (!pc[1]) begin
      rvc_c   = (w_data[1:0] != 2'b11);
      instr_c = rvc_c ? {16'h0, w_data[15:0]} : w_data;
    end else begin
      rvc_c   = (w_data[17:16] != 2'b11);
      instr_c = rvc_c ? {16'h0, w_data[31:16]} : {n_data[15:0], w_data[31:16]};
    end
  end
`else
  assign fault   = pc[1];
  assign need_n  = 1'b0;
  assign rvc_c   = 1'b0;
  assign instr_c = w_data;
`endif

  // W is always fetched first; once W is present N is either needed or prefetched.
  always_comb begin
    req_raw = 1'b0;
    req_tag = w_tag;
    if ((state_q == IDLE) && !fault) begin
      if (pend_q && !redirect) begin
        req_raw = 1'b1;
        req_tag = pend_tag_q;
      end else if (!w_hit) begin
        req_raw = 1'b1;
        req_tag = w_tag;
      end else if (!n_hit) begin
        req_raw = 1'b1;
        req_tag = n_tag;
      end
    end
  end

  always_comb begin
    if (!vld_q[0]) begin
      wr_sel = 1'b0;
    end else if (!vld_q[1]) begin
      wr_sel = 1'b1;
    end else if (tag_q[0] != w_tag) begin
      wr_sel = 1'b0;
    end else begin
      wr_sel = 1'b1;
    end
  end

  assign imem_req       = req_raw && !reset;
  assign imem_addr      = {req_tag, 2'b00};
  assign if_valid       = w_hit && (!need_n || n_hit) && !redirect && !fault && !reset;
  assign if_instr       = instr_c;
  assign if_rvc         = rvc_c;
  assign fetch_stall    = !if_valid;
  assign misalign_fault = fault && !reset;
  assign unused_bits    = ^{pc[0], n_data};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      vld_q      <= 2'b00;
      pend_q     <= 1'b0;
      pend_tag_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect) begin
            vld_q <= 2'b00;
          end
          pend_q     <= imem_req && !imem_ready;
          pend_tag_q <= req_tag;
          if (imem_req && imem_ready) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            vld_q   <= 2'b00;
            state_q <= imem_rvalid ? IDLE : DROP;
          end else if (imem_rvalid) begin
            tag_q[wr_sel]  <= pend_tag_q;
            data_q[wr_sel] <= imem_rdata;
            vld_q[wr_sel]  <= 1'b1;
            state_q        <= IDLE;
          end
        end
        DROP: begin
          if (redirect) begin
            vld_q <= 2'b00;
          end
          if (imem_rvalid) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// tb/tb_fetch_align.sv - directed scoreboard bench for fetch_align.
`timescale 1ns/1ps
module tb_fetch_align;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = 32'h0;
  logic        redirect = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        if_rvc;
  logic        fetch_stall;
  logic        misalign_fault;

  always #5 clock = ~clock;

  fetch_align #(.XLEN(32)) dut (
    .clock(clock), .reset(reset), .pc(pc), .redirect(redirect),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_rvc(if_rvc),
    .fetch_stall(fetch_stall), .misalign_fault(misalign_fault)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic        rvc;
  } exp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        sb_q[$];
  logic [31:0] addr_q[$];
  logic        auto_resp = 1'b1;
  logic [31:0] pend_addr = 32'h0;
  int          waited;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_1000: return 32'h0001_4501;
      32'h0000_1004: return 32'h0000_FFFF;
      32'h0000_1008: return 32'h0093_0013;
      32'h0000_100C: return 32'hABCD_0050;
      default:       return {a[15:0] ^ 16'h5A5A, a[15:2], 2'b11};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: record acceptance, then model a memory that answers the next cycle.
  task automatic tick();
    logic        acc;
    logic [31:0] aa;
    acc = imem_req && imem_ready;
    aa  = imem_addr;
    @(posedge clock);
    #1;
    imem_rvalid = 1'b0;
    if (acc) begin
      if (addr_q.size() > 0) chk("req_addr", aa, addr_q.pop_front());
      if (auto_resp) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(aa);
      end else begin
        pend_addr = aa;
      end
    end
    #1;
  endtask

  task automatic wait_instr(input string tag, input int maxc, output int w);
    exp_t e;
    w = 0;
    while (!if_valid && (w < maxc)) begin
      tick();
      w++;
    end
    chk({tag, "_valid"}, {31'h0, if_valid}, 32'h1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_instr"}, if_instr, e.instr);
      chk({tag, "_rvc"}, {31'h0, if_rvc}, {31'h0, e.rvc});
    end else begin
      chk({tag, "_sb_empty"}, 32'h0, 32'h1);
    end
  endtask

  task automatic settle();
    repeat (4) tick();
  endtask

  initial begin
    // Reset with pc[1]=1: outputs must still be quiet.
    pc = 32'h2;
    tick();
    tick();
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_stall", {31'h0, fetch_stall}, 32'h1);
    chk("rst_fault", {31'h0, misalign_fault}, 32'h0);

    // Stray response with nothing accepted is ignored.
    reset = 1'b0;
    pc = 32'h0;
    imem_ready = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    tick();
    chk("stray_valid", {31'h0, if_valid}, 32'h0);

    // Redirect to 0x0 with zero-wait memory.
    imem_ready = 1'b1;
    redirect = 1'b1;
    addr_q.push_back(32'h0);
    sb_q.push_back('{instr: 32'h0050_0093, rvc: 1'b0});
    #1;
    chk("r031_req", {31'h0, imem_req}, 32'h1);
    chk("r031_addr", imem_addr, 32'h0);
    tick();
    redirect = 1'b0;
    #1;
    chk("r031_c1_valid", {31'h0, if_valid}, 32'h0);
    wait_instr("r031", 6, waited);
    chk("r031_lat", waited, 1);

    // Sequential stream: one word every two cycles.
    for (int k = 1; k <= 3; k++) begin
      tick();
      pc = pc + 32'h4;
      sb_q.push_back('{instr: mem_word(pc), rvc: 1'b0});
      #1;
      wait_instr("seq", 6, waited);
      chk("seq_lat", waited, 1);
    end

    // Memory not ready for three cycles.
    settle();
    imem_ready = 1'b0;
    pc = 32'h200;
    redirect = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", {31'h0, imem_req}, 32'h1);
      chk("stall_addr", imem_addr, 32'h200);
      chk("stall_fs", {31'h0, fetch_stall}, 32'h1);
      tick();
      redirect = 1'b0;
      #1;
    end
    imem_ready = 1'b1;
    sb_q.push_back('{instr: mem_word(32'h200), rvc: 1'b0});
    #1;
    wait_instr("stall", 8, waited);
    chk("stall_lat", waited, 2);

    // Redirect while waiting: old response dropped.
    settle();
    auto_resp = 1'b0;
    pc = 32'h40;
    redirect = 1'b1;
    addr_q.push_back(32'h40);
    #1;
    tick();
    pc = 32'h100;
    redirect = 1'b1;
    #1;
    chk("drop_wait_req", {31'h0, imem_req}, 32'h0);
    tick();
    redirect = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = mem_word(pend_addr);
    #1;
    chk("drop_valid", {31'h0, if_valid}, 32'h0);
    chk("drop_req", {31'h0, imem_req}, 32'h0);
    auto_resp = 1'b1;
    addr_q.push_back(32'h100);
    sb_q.push_back('{instr: mem_word(32'h100), rvc: 1'b0});
    tick();
    chk("drop_idle_req", {31'h0, imem_req}, 32'h1);
    chk("drop_idle_addr", imem_addr, 32'h100);
    wait_instr("drop", 8, waited);
    chk("drop_lat", waited, 2);

    // Redirect coincident with the response: discard and go straight to IDLE.
    settle();
    auto_resp = 1'b0;
    pc = 32'h300;
    redirect = 1'b1;
    #1;
    tick();
    pc = 32'h340;
    redirect = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = mem_word(32'h300);
    #1;
    tick();
    redirect = 1'b0;
    auto_resp = 1'b1;
    #1;
    chk("coinc_req", {31'h0, imem_req}, 32'h1);
    chk("coinc_addr", imem_addr, 32'h340);
    sb_q.push_back('{instr: mem_word(32'h340), rvc: 1'b0});
    wait_instr("coinc", 8, waited);
    chk("coinc_lat", waited, 2);

`ifdef RVC_EN
    // Compressed halves of one word.
    settle();
    pc = 32'h1000;
    redirect = 1'b1;
    sb_q.push_back('{instr: 32'h0000_4501, rvc: 1'b1});
    #1;
    tick();
    redirect = 1'b0;
    #1;
    wait_instr("rvc_lo", 8, waited);
    tick();
    pc = 32'h1002;
    sb_q.push_back('{instr: 32'h0000_0001, rvc: 1'b1});
    #1;
    wait_instr("rvc_hi", 4, waited);

    // 32-bit instruction straddling two words.
    settle();
    pc = 32'h100A;
    redirect = 1'b1;
    addr_q.push_back(32'h1008);
    addr_q.push_back(32'h100C);
    sb_q.push_back('{instr: 32'h0050_0093, rvc: 1'b0});
    #1;
    tick();
    redirect = 1'b0;
    #1;
    wait_instr("strad", 10, waited);
    chk("strad_lat", waited, 3);
`else
    // Halfword pc without compressed support.
    settle();
    pc = 32'h6;
    redirect = 1'b1;
    #1;
    chk("mis_fault", {31'h0, misalign_fault}, 32'h1);
    chk("mis_req", {31'h0, imem_req}, 32'h0);
    chk("mis_valid", {31'h0, if_valid}, 32'h0);
    tick();
    redirect = 1'b0;
    #1;
    chk("mis_fault2", {31'h0, misalign_fault}, 32'h1);
    chk("mis_req2", {31'h0, imem_req}, 32'h0);
    chk("mis_valid2", {31'h0, if_valid}, 32'h0);
`endif

    chk("addr_q_drained", addr_q.size(), 0);
    chk("sb_q_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_align.md
FETCH_ALIGN -- requirements
Module: fetch_align

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/address width.
REQ-002 SHALL have port clock  in  1  rising-edge clock.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port pc  in  XLEN  current PC from the pc register; bit 0 ignored.
REQ-005 SHALL have port redirect  in  1  one-cycle pulse in the first cycle pc holds a non-sequential value (branch/jump/trap).
REQ-006 SHALL have port imem_req  out  1  instruction-memory request valid.
REQ-007 SHALL have port imem_addr  out  XLEN  request word address, bits [1:0]=0.
REQ-008 SHALL have port imem_ready  in  1  request accepted when imem_req & imem_ready.
REQ-009 SHALL have port imem_rvalid  in  1  response data valid, in order, at most one outstanding.
REQ-010 SHALL have port imem_rdata  in  32  response word.
REQ-011 SHALL have port if_valid  out  1  if_instr holds the complete instruction at pc.
REQ-012 SHALL have port if_instr  out  32  instruction; RVC as {16'h0, halfword}.
REQ-013 SHALL have port if_rvc  out  1  instruction is 16-bit (instr[1:0]!=2'b11); feeds next-PC s_rvc.
REQ-014 SHALL have port fetch_stall  out  1  equals !if_valid; ORed into pc pause by the core.
REQ-015 SHALL have port misalign_fault  out  1  pc[1]=1 while compressed support absent.

Function
REQ-016 SHALL hold a two-entry word buffer, each entry {tag[XLEN-1:2], data[31:0], valid}; lookup by tag compare, no ordering between entries.
REQ-017 SHALL define W = word at pc[XLEN-1:2], N = word at W+4; needed set: W always; N also when pc[1]=1 and W[17:16]==2'b11.
REQ-018 SHALL assert if_valid combinationally when all needed words hit and redirect=0; if_instr = W (pc[1]=0), W[31:16] (RVC at pc[1]=1), {N[15:0],W[31:16]} (straddling 32-bit).
REQ-019 SHALL use FSM IDLE, WAIT, DROP.
REQ-020 IDLE: SHALL drive imem_req=1 with imem_addr = first missing needed word (W before N); if none missing and N absent, SHALL prefetch N; imem_req held with stable address until imem_ready; accept -> WAIT.
REQ-021 WAIT: imem_req=0; imem_rvalid -> write rdata into entry whose tag != W tag (invalid entry preferred), -> IDLE.
REQ-022 redirect in IDLE: SHALL invalidate both entries at the edge and treat them invalid combinationally that cycle; request for new W issued same cycle.
REQ-023 redirect in WAIT without rvalid: SHALL invalidate buffer, -> DROP; redirect with rvalid same cycle: discard data, invalidate, -> IDLE.
REQ-024 DROP: imem_req=0; next imem_rvalid discarded, -> IDLE; redirect in DROP invalidates again, stays DROP.
REQ-025 Latency: redirect to word-aligned pc, zero-wait memory (ready=1, rvalid next cycle) -> if_valid two cycles after redirect; sequential throughput one word per two cycles.
REQ-026 SHALL keep buffer contents across pc advance; a stale entry SHALL be overwritten only on the next fill.

Reset
REQ-027 During reset SHALL force imem_req=0, if_valid=0, misalign_fault=0, fetch_stall=1.
REQ-028 At reset edge SHALL enter IDLE and clear both valid bits; a response arriving later with no accepted request SHALL be ignored.

Configuration
REQ-029 Macro RVC_EN defined: halfword alignment, straddling assembly and if_rvc as above; misalign_fault tied 0.
REQ-030 Macro RVC_EN undefined: needed set is W only, if_instr=W, if_rvc=0; pc[1]=1 -> misalign_fault=1, if_valid=0, no request issued.

Verification
REQ-031 Reset then redirect to pc=0x0, ready=1, rvalid next cycle with 0x00500093 -> if_valid=1, if_instr=0x00500093, if_rvc=0 two cycles after redirect.
REQ-032 RVC_EN, words 0x0: 0x00014501, 0x4: 0x0000FFFF -> pc=0x0 if_instr=0x4501 if_rvc=1; pc=0x2 if_instr=0x0001 if_rvc=1.
REQ-033 RVC_EN, word 0x8=0x0093xxxx upper half 0x0093 with [17:16]=11, word 0xC low half 0x0050, pc=0xA -> requests 0x8 then 0xC, if_instr=0x00500093 after both fills.
REQ-034 Redirect to 0x100 while WAIT on 0x40 -> DROP, response for 0x40 discarded, next imem_addr=0x100, if_valid only with 0x100 data.
REQ-035 imem_ready=0 for 3 cycles -> imem_req and imem_addr stable all 3 cycles, fetch_stall=1 throughout.
REQ-036 RVC_EN undefined, redirect to pc=0x6 -> misalign_fault=1, imem_req=0, if_valid=0.
